// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with a two-flop row synchroniser and
// press/release debounce; emits one {row,col} code strobe per physical press.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic       IN_clk,
    input  logic       IN_reset,
    input  logic [3:0] IN_row,
    output logic [3:0] OUT_col,
    output logic [3:0] OUT_value,
    output logic       OUT_key,
    output logic [1:0] OUT_state
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DwellMax = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DebMax   = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        StScan     = 2'd0,
        StDebounce = 2'd1,
        StHold     = 2'd2,
        StRelease  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    row_meta_q, row_s_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0]    value_q, value_d;
    logic          key_q, key_d;

    logic [1:0]    low_row;
    logic          row_low;
    logic [3:0]    col_one;

    // Row 0 has highest priority when several rows read low together.
    always_comb begin
        low_row = 2'd0;
        if (!row_s_q[0]) begin
            low_row = 2'd0;
        end else if (!row_s_q[1]) begin
            low_row = 2'd1;
        end else if (!row_s_q[2]) begin
            low_row = 2'd2;
        end else begin
            low_row = 2'd3;
        end
    end

    assign row_low = ~row_s_q[row_idx_q];

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        value_d   = value_q;
        key_d     = 1'b0;

        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellMax) begin
                    dwell_d = '0;
                    if (row_s_q != 4'hF) begin
                        row_idx_d = low_row;
                        deb_d     = '0;
                        state_d   = StDebounce;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StDebounce: begin
                if (row_low) begin
                    if (deb_q == DebMax) begin
                        key_d   = 1'b1;
                        value_d = {row_idx_q, col_idx_q};
                        state_d = StHold;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    state_d   = StScan;
                end
            end
            StHold: begin
                if (!row_low) begin
                    deb_d   = '0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (row_low) begin
                    deb_d   = '0;
                    state_d = StHold;
                end else if (deb_q == DebMax) begin
                    deb_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    state_d   = StScan;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge IN_clk) begin
        if (!IN_reset) begin
            state_q    <= StScan;
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
            col_idx_q  <= 2'd0;
            row_idx_q  <= 2'd0;
            dwell_q    <= '0;
            deb_q      <= '0;
            value_q    <= 4'h0;
            key_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_meta_q <= IN_row;
            row_s_q    <= row_meta_q;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            dwell_q    <= dwell_d;
            deb_q      <= deb_d;
            value_q    <= value_d;
            key_q      <= key_d;
        end
    end

    assign col_one   = 4'b0001 << col_idx_q;
    assign OUT_col   = ~col_one;
    assign OUT_value = value_q;
    assign OUT_key   = key_q;
    assign OUT_state = state_q;

endmodule
